// File: rtl/unpadder.sv
// Unpadder: removes padding from 72-byte blocks and streams the message as 32-bit words.
// Optional padding checks are compiled in when `UNPADDER_CHECK_EN is defined.
module unpadder (
    input  logic         clk,
    input  logic         reset,
    input  logic [575:0] in,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ack,
    output logic [31:0]  out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         is_last,
    output logic [1:0]   byte_num,
    output logic         pad_err
);
    typedef enum logic [1:0] {IDLE, SCAN, SEND, ACK} state_e;
    localparam int NWORDS = 18;

    state_e      state_q, state_d;
    logic [31:0] words_q [NWORDS];
    logic [31:0] words_d [NWORDS];
    logic [31:0] mwords  [NWORDS];
    logic [4:0]  cnt_q, cnt_d, limit_q, limit_d, nxt;
    logic        last_q, last_d;
    logic [1:0]  fin_bn_q, fin_bn_d;
    logic [31:0] out_q, out_d;
    logic        out_valid_q, out_valid_d, is_last_q, is_last_d;
    logic [1:0]  byte_num_q, byte_num_d;
    logic        xfer;
    logic [6:0]  p;

    function automatic logic [31:0] keep_bytes(input logic [31:0] w, input logic [1:0] n);
        return w & ~(32'hFFFF_FFFF >> {n, 3'b000});
    endfunction

    assign xfer = out_valid_q & out_ready;
    assign nxt  = cnt_q + 5'd1;

    // Pad position: highest nonzero byte once the 0x80 end marker in byte 71 is masked.
    always_comb begin
        for (int k = 0; k < NWORDS; k++) mwords[k] = words_q[k];
        mwords[NWORDS-1] = words_q[NWORDS-1] & ~32'h0000_0080;
        p = '0;
        for (int k = 0; k < NWORDS; k++) begin
            for (int m = 0; m < 4; m++) begin
                if (mwords[k][31-8*m -: 8] != 8'h00) p = 7'(4*k + m);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = in_last ? SCAN : SEND;
            SCAN:    state_d = SEND;
            SEND:    if (xfer && nxt == limit_q) state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ack = (state_q == ACK);
    end

    always_comb begin
        words_d     = words_q;
        cnt_d       = cnt_q;
        limit_d     = limit_q;
        last_d      = last_q;
        fin_bn_d    = fin_bn_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        is_last_d   = is_last_q;
        byte_num_d  = byte_num_q;
        case (state_q)
            IDLE: if (in_valid) begin
                for (int k = 0; k < NWORDS; k++) words_d[k] = in[575-32*k -: 32];
                cnt_d    = '0;
                last_d   = in_last;
                fin_bn_d = '0;
                if (!in_last) begin
                    limit_d     = 5'(NWORDS);
                    out_d       = in[575 -: 32];
                    out_valid_d = 1'b1;
                    is_last_d   = 1'b0;
                    byte_num_d  = '0;
                end
            end
            SCAN: begin
                limit_d     = p[6:2] + 5'd1;
                fin_bn_d    = p[1:0];
                out_valid_d = 1'b1;
                if (p[6:2] == 5'd0) begin
                    out_d      = keep_bytes(words_q[0], p[1:0]);
                    is_last_d  = 1'b1;
                    byte_num_d = p[1:0];
                end else begin
                    out_d      = words_q[0];
                    is_last_d  = 1'b0;
                    byte_num_d = '0;
                end
            end
            SEND: if (xfer) begin
                if (nxt == limit_q) begin
                    out_valid_d = 1'b0;
                    out_d       = '0;
                    is_last_d   = 1'b0;
                    byte_num_d  = '0;
                end else begin
                    cnt_d = nxt;
                    if (last_q && nxt == limit_q - 5'd1) begin
                        out_d      = keep_bytes(words_q[nxt], fin_bn_q);
                        is_last_d  = 1'b1;
                        byte_num_d = fin_bn_q;
                    end else begin
                        out_d      = words_q[nxt];
                        is_last_d  = 1'b0;
                        byte_num_d = '0;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the block store is reset too, so an aborted block leaves nothing behind.
            for (int k = 0; k < NWORDS; k++) words_q[k] <= '0;
            cnt_q       <= '0;
            limit_q     <= '0;
            last_q      <= 1'b0;
            fin_bn_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            is_last_q   <= 1'b0;
            byte_num_q  <= '0;
        end else begin
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            limit_q     <= limit_d;
            last_q      <= last_d;
            fin_bn_q    <= fin_bn_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            is_last_q   <= is_last_d;
            byte_num_q  <= byte_num_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign is_last   = is_last_q;
    assign byte_num  = byte_num_q;

`ifdef UNPADDER_CHECK_EN
    logic        pad_err_q, pad_err_d;
    logic [31:0] pad_word;
    logic [7:0]  pad_byte;
    logic        bad_pad;

    // An all-zero block gives p=0 with byte 0 == 0x00, so it fails the 0x01 test as well.
    always_comb begin
        pad_word  = mwords[p[6:2]];
        pad_byte  = 8'(pad_word >> {~p[1:0], 3'b000});
        bad_pad   = (pad_byte != 8'h01) || !words_q[NWORDS-1][7];
        pad_err_d = pad_err_q | ((state_q == SCAN) && bad_pad);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pad_err_q <= 1'b0;
        else        pad_err_q <= pad_err_d;
    end

    assign pad_err = pad_err_q;
`else
    assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_unpadder.sv
// Self-checking bench for unpadder: table of blocks, scoreboard of expected words,
// plus hand-written sequences for the literal-block and mid-block reset cases.
`timescale 1ns/1ps
module tb_unpadder;
    logic         clk = 1'b0;
    logic         reset;
    logic [575:0] in;
    logic         in_valid, in_last, in_ack;
    logic [31:0]  out;
    logic         out_valid, out_ready, is_last, pad_err;
    logic [1:0]   byte_num;

    always #5 clk = ~clk;

    unpadder dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_last(in_last),
        .in_ack(in_ack), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .is_last(is_last), .byte_num(byte_num), .pad_err(pad_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  bn;
    } exp_t;

    typedef struct {
        int len;
        bit last;
        int seed;
        bit bad71;
        bit toggle;
        int exp_words;
        int exp_bn;
    } vec_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   exp_err  = 1'b0;
`ifdef UNPADDER_CHECK_EN
    localparam bit CHECKING = 1'b1;
`else
    localparam bit CHECKING = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Builds the block for a vector and pushes the words it must produce.
    task automatic build(input vec_t v, output logic [575:0] blk);
        logic [7:0]  b [72];
        logic [31:0] w;
        int          nw;
        exp_t        e;
        for (int j = 0; j < 72; j++) b[j] = 8'h00;
        if (!v.last) begin
            for (int j = 0; j < 72; j++)
                b[j] = (v.seed == 0) ? ((j % 4 == 3) ? 8'(j / 4) : 8'h00) : 8'(j * 29 + v.seed);
            for (int k = 0; k < 18; k++) begin
                e.data = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
                e.last = 1'b0;
                e.bn   = 2'd0;
                exp_q.push_back(e);
            end
        end else begin
            for (int j = 0; j < v.len; j++) b[j] = 8'(j * 29 + v.seed + 1);
            b[v.len] = 8'h01;
            if (!v.bad71) b[71] = b[71] | 8'h80;
            nw = v.len / 4 + 1;
            for (int k = 0; k < nw; k++) begin
                w = '0;
                for (int m = 0; m < 4; m++) w = {w[23:0], (4*k + m < v.len) ? b[4*k+m] : 8'h00};
                e.data = w;
                e.last = (k == nw - 1);
                e.bn   = (k == nw - 1) ? 2'(v.len % 4) : 2'd0;
                exp_q.push_back(e);
            end
        end
        for (int j = 0; j < 72; j++) blk[575-8*j -: 8] = b[j];
    endtask

    // Presents one block and drains it; kill_after >= 0 stops after that word index is transferred.
    task automatic run_block(input logic [575:0] blk, input bit last, input bit toggle,
                             input int kill_after, output int nwords, output int last_bn);
        bit          done, held, rdy_ph;
        logic [34:0] held_vec;
        exp_t        e;
        done    = 1'b0;
        held    = 1'b0;
        rdy_ph  = 1'b1;
        nwords  = 0;
        last_bn = -1;
        @(negedge clk);
        in        = blk;
        in_valid  = 1'b1;
        in_last   = last;
        out_ready = 1'b0;
        @(negedge clk);
        check("first_word_latency", out_valid, !last);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (held && out_valid) check("word_held_stable", {out, is_last, byte_num}, held_vec);
            held = 1'b0;
            if (in_ack) begin
                check("ack_after_last_word", exp_q.size(), 0);
                in_valid = 1'b0;
                done     = 1'b1;
                @(negedge clk);
                check("ack_single_pulse", {in_ack, out_valid}, 2'b00);
            end else if (out_valid) begin
                out_ready = toggle ? rdy_ph : 1'b1;
                rdy_ph    = ~rdy_ph;
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", {out, is_last, byte_num}, 35'h0_0000_0000 - 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {out, is_last, byte_num}, {e.data, e.last, e.bn});
                    end
                    if (is_last) last_bn = int'(byte_num);
                    nwords++;
                    if (kill_after >= 0 && nwords == kill_after + 1) done = 1'b1;
                end else begin
                    held     = 1'b1;
                    held_vec = {out, is_last, byte_num};
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        if (!done) check("block_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        vec_t         tbl [10];
        logic [575:0] blk;
        int           nw, lbn;
        bit           no_ack;
        exp_t         e;

        tbl = '{
            '{0,  1'b0, 0,  1'b0, 1'b0, 18, -1},
            '{3,  1'b1, 5,  1'b0, 1'b0, 1,  3},
            '{8,  1'b1, 11, 1'b0, 1'b0, 3,  0},
            '{71, 1'b1, 3,  1'b0, 1'b1, 18, 3},
            '{0,  1'b1, 0,  1'b0, 1'b0, 1,  0},
            '{5,  1'b1, 7,  1'b0, 1'b1, 2,  1},
            '{0,  1'b0, 9,  1'b0, 1'b1, 18, -1},
            '{66, 1'b1, 2,  1'b0, 1'b0, 17, 2},
            '{10, 1'b1, 4,  1'b1, 1'b0, 3,  2},
            '{13, 1'b1, 6,  1'b0, 1'b0, 4,  1}
        };

        reset     = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset_state", {out, out_valid, is_last, byte_num, in_ack, pad_err}, '0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            build(tbl[i], blk);
            run_block(blk, tbl[i].last, tbl[i].toggle, -1, nw, lbn);
            check("word_count", nw, tbl[i].exp_words);
            check("final_byte_num", lbn, tbl[i].exp_bn);
            if (tbl[i].bad71 && CHECKING) exp_err = 1'b1;
            check("pad_err", pad_err, exp_err);
            exp_q.delete();
        end

        // Literal block: message AABBCC, pad 0x01 at byte 3, end marker 0x80 at byte 71.
        blk    = {32'hAABB_CC01, {16{32'h0000_0000}}, 32'h0000_0080};
        e.data = 32'hAABB_CC00;
        e.last = 1'b1;
        e.bn   = 2'd3;
        exp_q.push_back(e);
        run_block(blk, 1'b1, 1'b0, -1, nw, lbn);
        check("aabbcc_word_count", nw, 1);
        check("aabbcc_pad_err_sticky", pad_err, exp_err);

        // Reset asserted right after word 5 of a non-last block.
        build('{0, 1'b0, 13, 1'b0, 1'b0, 18, -1}, blk);
        run_block(blk, 1'b0, 1'b0, 5, nw, lbn);
        @(posedge clk);
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset_mid_block", {out, out_valid, is_last, byte_num, in_ack, pad_err}, '0);
        exp_q.delete();
        exp_err = 1'b0;
        no_ack  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ack || out_valid) no_ack = 1'b0;
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ack || out_valid) no_ack = 1'b0;
        end
        check("no_ack_for_aborted_block", no_ack, 1'b1);

        build('{7, 1'b1, 21, 1'b0, 1'b0, 2, 3}, blk);
        run_block(blk, 1'b1, 1'b0, -1, nw, lbn);
        check("post_reset_word_count", nw, 2);
        check("post_reset_byte_num", lbn, 3);
        check("post_reset_pad_err", pad_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unpadder.md
UNPADDER -- requirements
Module: unpadder

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset; asserting 0 clears all state immediately.
REQ-003 in  input  576  padded 72-byte block; word k (k=0..17) = in[575-32k -: 32]; byte 0 of each word = bits [31:24].
REQ-004 in_valid  input  1  block on in is presented; held with in stable until in_ack.
REQ-005 in_last  input  1  presented block is the final (padded) block of the message; qualified by in_valid.
REQ-006 in_ack  output  1  one-cycle pulse; block consumed, upstream may change in.
REQ-007 out  output  32  message word.
REQ-008 out_valid  output  1  out, is_last, byte_num valid.
REQ-009 out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
REQ-010 is_last  output  1  current word is the final word of the message.
REQ-011 byte_num  output  2  valid bytes in the is_last word (0..3, from bits [31:24] down); 0 when is_last=0.
REQ-012 pad_err  output  1  sticky; malformed padding detected in a last block.

Function
REQ-013 States IDLE, SCAN, SEND, ACK; reset state IDLE.
REQ-014 IDLE: in_valid=1 -> load in into 576-bit block register, word counter=0; go to SCAN if in_last=1, else to SEND with word limit 18.
REQ-015 SCAN (exactly one cycle): mask bit 7 of byte 71; p = index of highest-numbered nonzero byte (0..71); word limit = floor(p/4)+1, final byte_num = p mod 4; go to SEND.
REQ-016 SEND: out_valid=1; out = current word with bytes at index >= p forced to 0 on the final word of a last block.
REQ-017 Each transfer advances the counter by one word; out_valid stays high with out stable while out_ready=0.
REQ-018 is_last=1 only on the final word of a last block; on a non-last block all 18 words have is_last=0.
REQ-019 p mod 4 = 0 -> final word is emitted with byte_num=0 and out=0 (empty terminator word).
REQ-020 Transfer of the last word -> ACK; ACK asserts in_ack for one cycle, then IDLE; earliest next load is the cycle after ACK.
REQ-021 Minimum latency: in_valid sampled in IDLE at edge n -> out_valid at n+1 (non-last) or n+2 (last).
REQ-022 Throughput with out_ready=1: one word per cycle; non-last block occupies 20 cycles IDLE-to-IDLE.
REQ-023 in_valid is ignored in SCAN, SEND and ACK.
REQ-024 out, out_valid, is_last, byte_num are driven from registers (no combinational path from out_ready or in).

Reset
REQ-025 reset=0 at any time, including mid-block -> IDLE; out_valid=0, in_ack=0, is_last=0, byte_num=0, out=0, pad_err=0, counter=0; partial block discarded, no in_ack issued for it.
REQ-026 Release of reset takes effect on the next rising edge; first possible load is that edge.

Configuration
REQ-027 Macro UNPADDER_CHECK_EN defined: in SCAN, pad_err sets if byte p != 0x01 (byte p = 0x81 accepted when p=71), or byte 71 bit 7 = 0, or all masked bytes are zero (p forced to 0); block is still emitted.
REQ-028 UNPADDER_CHECK_EN undefined: no checking logic, pad_err tied to 0, p computed as in REQ-015 (all-zero -> p=0).

Verification
REQ-029 Non-last block of words 0x00000000..0x00000011, out_ready=1 -> 18 words in order, is_last=0, in_ack one pulse after word 17.
REQ-030 Last block with message 0xAABBCC, byte 3=0x01, byte 71=0x80 -> one word 0xAABBCC00, is_last=1, byte_num=3, pad_err=0.
REQ-031 Last block with 8 message bytes, byte 8=0x01 -> 3 words, third out=0x00000000, is_last=1, byte_num=0.
REQ-032 Last block with 71 message bytes, byte 71=0x81 -> 18 words, final byte_num=3, pad_err=0; out_ready toggled 1/0 every cycle -> words held stable and none dropped or duplicated.
REQ-033 Reset=0 asserted after word 5 of a block -> outputs cleared same cycle, no in_ack; new block loaded after release emitted from word 0.
REQ-034 With UNPADDER_CHECK_EN: last block with byte 71=0x00 -> pad_err=1 and held until reset; without it pad_err stays 0.
